// File: rtl/cpu_load_return_pkg.sv
// Shared widths, access-size codes and the queued entry layout for the load-return buffer.
package cpu_load_return_pkg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int SIZE_W = 2;

    // Access format codes carried with every returning load
    localparam logic [SIZE_W-1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] MEM_SIZE_WORD = 2'd2;

    // One queued load: raw memory word plus everything needed to format and retire it
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic [SIZE_W-1:0] size;
        logic [1:0]        offset;
        logic              isSigned;
    } load_entry_t;

endpackage

// File: rtl/cpu_load_return_load_format.sv
// Little-endian lane extraction and sign/zero extension of a raw aligned load word.
module load_format
    import cpu_load_return_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [1:0]        i_offset,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_result
);

    logic [7:0]  w_byteLane;
    logic [15:0] w_halfLane;

    // Byte lane picked by the full offset; half lane uses only offset[1]
    assign w_byteLane = i_data[{i_offset, 3'b000} +: 8];
    assign w_halfLane = i_offset[1] ? i_data[31:16] : i_data[15:0];

    // Extend the selected lane; word and the reserved code pass the word through untouched
    always_comb begin
        o_result = i_data;
        case (i_size)
            MEM_SIZE_BYTE: o_result = {{24{i_signed & w_byteLane[7]}}, w_byteLane};
            MEM_SIZE_HALF: o_result = {{16{i_signed & w_halfLane[15]}}, w_halfLane};
            default:       o_result = i_data;
        endcase
    end

endmodule

// File: rtl/cpu_load_return.sv
// Load-return FIFO feeding the completion stage: queues returning loads and
// emits one formatted result per free regfile write slot as a registered pulse.
module cpu_load_return
    import cpu_load_return_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DEST_W-1:0] mem_dest,
    input  logic [SIZE_W-1:0] mem_size,
    input  logic [1:0]        mem_offset,
    input  logic              mem_signed,
    input  logic              slot_free,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] read_data,
    output logic [DEST_W-1:0] read_dest,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_almost_full,
    output logic              overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    load_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_cpuReady;
    logic [DATA_W-1:0] r_readData;
    logic [DEST_W-1:0] r_readDest;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    load_entry_t       w_wrEntry;
    load_entry_t       w_rdEntry;
    logic [DATA_W-1:0] w_fmtData;

    // Full/empty come from the registered count only, so a push into a full
    // FIFO is dropped even when a pop frees a slot on the same edge
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push    = mem_valid & ~w_full;
    assign w_pop     = slot_free & ~w_empty;

    assign w_wrEntry = '{data: mem_data, dest: mem_dest, size: mem_size,
                         offset: mem_offset, isSigned: mem_signed};
    assign w_rdEntry = r_mem[r_rdPtr];

    load_format u_format (
        .i_data   (w_rdEntry.data),
        .i_size   (w_rdEntry.size),
        .i_offset (w_rdEntry.offset),
        .i_signed (w_rdEntry.isSigned),
        .o_result (w_fmtData)
    );

    // Entry storage needs no reset; the count decides which slots are live
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_wrEntry;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop balance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a returning load that found no room
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (mem_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Registered result: one ready pulse per pop, data held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cpuReady <= 1'b0;
            r_readData <= '0;
            r_readDest <= '0;
        end else begin
            r_cpuReady <= w_pop;
            if (w_pop) begin
                r_readData <= w_fmtData;
                r_readDest <= w_rdEntry.dest;
            end
        end
    end

    assign cpu_ready        = r_cpuReady;
    assign read_data        = r_readData;
    assign read_dest        = r_readDest;
    assign fifo_empty       = w_empty;
    assign fifo_full        = w_full;
    assign fifo_almost_full = (r_count >= CNT_W'(DEPTH - AFULL_MARGIN));
    assign overflow_err     = r_overflow;

endmodule

// File: tb/tb_cpu_load_return.sv
// Scoreboard bench for cpu_load_return: a queue-level model predicts every
// result and flag, and a negedge monitor compares whatever the DUT presents.
module tb_cpu_load_return;

    localparam int DEPTH  = 4;
    localparam int AFULL  = 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
    } result_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic [4:0]  mem_dest = '0;
    logic [1:0]  mem_size = '0;
    logic [1:0]  mem_offset = '0;
    logic        mem_signed = 1'b0;
    logic        slot_free = 1'b0;
    logic        cpu_ready;
    logic [31:0] read_data;
    logic [4:0]  read_dest;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        overflow_err;

    int      checks = 0;
    int      failures = 0;
    bit      checkEn = 1'b0;
    bit      modelOvf = 1'b0;
    result_t modelQ[$];
    result_t expQ[$];

    cpu_load_return #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .mem_valid        (mem_valid),
        .mem_data         (mem_data),
        .mem_dest         (mem_dest),
        .mem_size         (mem_size),
        .mem_offset       (mem_offset),
        .mem_signed       (mem_signed),
        .slot_free        (slot_free),
        .cpu_ready        (cpu_ready),
        .read_data        (read_data),
        .read_dest        (read_dest),
        .fifo_empty       (fifo_empty),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .overflow_err     (overflow_err)
    );

    always #5 clock = ~clock;

    // Reference formatting from the little-endian lane rules, using shifts and masks
    function automatic logic [31:0] refFormat(input logic [31:0] d, input logic [1:0] sz,
                                              input logic [1:0] off, input bit sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * int'(off))) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the edge from its pre-edge occupancy
    task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [4:0] dst,
                                 input logic [1:0] sz, input logic [1:0] off, input bit sg,
                                 input bit sf);
        int preSize;
        result_t r;
        mem_valid  = v;
        mem_data   = d;
        mem_dest   = dst;
        mem_size   = sz;
        mem_offset = off;
        mem_signed = sg;
        slot_free  = sf;
        @(posedge clock);
        if (reset_n) begin
            preSize = modelQ.size();
            if (sf && preSize > 0) expQ.push_back(modelQ.pop_front());
            if (v) begin
                if (preSize < DEPTH) begin
                    r.data = refFormat(d, sz, off, sg);
                    r.dest = dst;
                    modelQ.push_back(r);
                end else begin
                    modelOvf = 1'b1;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input bit sf, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 5'd0, 2'd0, 2'd0, 1'b0, sf);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        checkOutput({tag, "_data"}, read_data, 32'd0);
        checkOutput({tag, "_dest"}, 32'(read_dest), 32'd0);
        checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        checkOutput({tag, "_full"}, 32'(fifo_full), 32'd0);
        checkOutput({tag, "_afull"}, 32'(fifo_almost_full), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    endtask

    // Monitor: flags against model occupancy, and every ready pulse against the scoreboard
    initial begin
        result_t e;
        forever begin
            @(negedge clock);
            if (checkEn && reset_n) begin
                checkOutput("empty", 32'(fifo_empty), 32'(modelQ.size() == 0));
                checkOutput("full", 32'(fifo_full), 32'(modelQ.size() == DEPTH));
                checkOutput("afull", 32'(fifo_almost_full), 32'(modelQ.size() >= DEPTH - AFULL));
                checkOutput("overflow", 32'(overflow_err), 32'(modelOvf));
                checkOutput("ready", 32'(cpu_ready), 32'(expQ.size() > 0));
                if (cpu_ready && expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("read_data", read_data, e.data);
                    checkOutput("read_dest", 32'(read_dest), 32'(e.dest));
                end else if (expQ.size() > 0) begin
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0] seqDest;
        #1 reset_n = 1'b0;
        #1 checkResetValues("por");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Signed byte at offset 1 with slot held free: ready exactly two edges after the push
        applyStimulus(1'b1, 32'h8899_AABB, 5'd3, 2'd0, 2'd1, 1'b1, 1'b1);
        checkOutput("lat_early", 32'(cpu_ready), 32'd0);
        idle(1'b1, 1);
        checkOutput("lat_ready", 32'(cpu_ready), 32'd1);
        checkOutput("lat_data", read_data, 32'hFFFF_FFAA);
        idle(1'b1, 2);

        // Half at offset 2 unsigned, word with ignored offset
        applyStimulus(1'b1, 32'h8001_1234, 5'd7, 2'd1, 2'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd8, 2'd2, 2'd3, 1'b1, 1'b1);
        idle(1'b1, 3);

        // Fill with no free slots, overflow, then drain in order
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 5'(i), 2'd2, 2'd0, 1'b0, 1'b0);
        checkOutput("fill_full", 32'(fifo_full), 32'd1);
        applyStimulus(1'b1, 32'hBAD0_0005, 5'd5, 2'd2, 2'd0, 1'b0, 1'b0);
        checkOutput("fill_ovf", 32'(overflow_err), 32'd1);
        idle(1'b1, 6);

        // Full FIFO with push and pop on the same edge: push dropped
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 5'(10 + i), 2'd0, 2'(i), 1'(i), 1'b0);
        applyStimulus(1'b1, 32'hBAD0_0099, 5'd31, 2'd2, 2'd0, 1'b0, 1'b1);
        idle(1'b1, 6);

        // Count 2 with simultaneous push and pop
        applyStimulus(1'b1, 32'h0000_8081, 5'd20, 2'd0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_8081, 5'd21, 2'd0, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFE_0001, 5'd22, 2'd1, 2'd3, 1'b1, 1'b1);
        idle(1'b1, 5);

        // Queue three, start draining, then reset asynchronously mid-drain
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 5'(24 + i), 2'd2, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1 checkResetValues("async");
        modelQ.delete();
        expQ.delete();
        modelOvf = 1'b0;
        idle(1'b1, 2);
        reset_n = 1'b1;
        idle(1'b1, 4);

        // Continuous pushes with alternating slots: fills, overflows, wraps pointers
        seqDest = 5'd1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, $urandom, seqDest, 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'(i % 2 == 0));
            seqDest = seqDest + 5'd1;
        end
        idle(1'b1, 6);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, 5'($urandom),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 50));
        end
        idle(1'b1, 8);

        checkOutput("drained_model", 32'(modelQ.size()), 32'd0);
        checkOutput("drained_scoreboard", 32'(expQ.size()), 32'd0);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
